// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with a valid/ready load handshake.
// An optional advance strobe gates each bit step, like a flip-flop enable.
module piso_tx #(
   parameter int WIDTH     = 8,
   parameter int USE_EN    = 1,
   parameter int LSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;

   logic             advance;
   logic [WIDTH-1:0] shreg_next;
   logic             first_bit;
   logic             next_bit;

   assign advance    = (USE_EN != 0) ? en : 1'b1;
   assign shreg_next = (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);
   assign first_bit  = (LSB_FIRST != 0) ? din[0] : din[WIDTH-1];
   assign next_bit   = (LSB_FIRST != 0) ? shreg_next[0] : shreg_next[WIDTH-1];

   // Outputs are registered alongside the state so each one reflects the
   // state being entered; sout is preloaded with the bit that will be shown.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         shreg      <= '0;
         cnt        <= '0;
         din_ready  <= 1'b1;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (din_valid) begin
                  state      <= SHIFT;
                  shreg      <= din;
                  cnt        <= '0;
                  din_ready  <= 1'b0;
                  busy       <= 1'b1;
                  sout_valid <= 1'b1;
                  sout       <= first_bit;
               end
            end
            SHIFT: begin
               if (advance) begin
                  if (cnt == LAST) begin
                     state      <= DONE;
                     busy       <= 1'b0;
                     sout_valid <= 1'b0;
                     sout       <= 1'b0;
                     done       <= 1'b1;
                  end else begin
                     shreg <= shreg_next;
                     cnt   <= cnt + 1'b1;
                     sout  <= next_bit;
                  end
               end
            end
            DONE: begin
               state     <= IDLE;
               done      <= 1'b0;
               din_ready <= 1'b1;
            end
            default: begin
               state      <= IDLE;
               din_ready  <= 1'b1;
               busy       <= 1'b0;
               sout_valid <= 1'b0;
               sout       <= 1'b0;
               done       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: two instances (gated LSB-first, ungated MSB-first) checked
// by a bit-level scoreboard fed at each load handshake.
module tb_piso_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en  = 1'b0;
   logic [7:0] din        [2];
   logic       din_valid  [2];
   logic       din_ready  [2];
   logic       sout       [2];
   logic       sout_valid [2];
   logic       busy       [2];
   logic       done       [2];

   int vectors   = 0;
   int miscomp   = 0;
   int cyc       = 0;
   bit mon_en    = 1'b0;
   int done_cyc  [2];
   // Expected serial stream per instance: 0/1 = bit, 2 = done pulse due.
   int exp_q     [2][$];
   logic adv;

   piso_tx #(.WIDTH(8), .USE_EN(1), .LSB_FIRST(1)) u_lsb (
      .clk(clk), .rst(rst), .en(en), .din(din[0]), .din_valid(din_valid[0]),
      .din_ready(din_ready[0]), .sout(sout[0]), .sout_valid(sout_valid[0]),
      .busy(busy[0]), .done(done[0]));

   piso_tx #(.WIDTH(8), .USE_EN(0), .LSB_FIRST(0)) u_msb (
      .clk(clk), .rst(rst), .en(en), .din(din[1]), .din_valid(din_valid[1]),
      .din_ready(din_ready[1]), .sout(sout[1]), .sout_valid(sout_valid[1]),
      .busy(busy[1]), .done(done[1]));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscomp++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Reference: the frame is just the word's bits in transmit order.
   task automatic push_frame(input int d, input logic [7:0] w);
      for (int k = 0; k < 8; k++)
         exp_q[d].push_back((d == 0) ? int'(w[k]) : int'(w[7-k]));
      exp_q[d].push_back(2);
   endtask

   task automatic send(input int d, input logic [7:0] w, output int hs);
      int t = 0;
      hs = -1;
      din[d] = w;
      din_valid[d] = 1'b1;
      while (!din_ready[d] && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 200) begin
         chk("load_timeout", 0, 1);
      end else begin
         @(posedge clk);
         hs = cyc;
         push_frame(d, w);
         #1;
         din_valid[d] = 1'b0;
      end
   endtask

   // mode: 0 en=1, 1 en=0, 2 random en
   task automatic drain(input int d, input int mode);
      int t = 0;
      while (exp_q[d].size() > 0 && t < 500) begin
         en = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         t++;
      end
      chk($sformatf("drain_d%0d", d), exp_q[d].size(), 0);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         for (int d = 0; d < 2; d++) begin
            adv = (d == 0) ? en : 1'b1;
            if (done[d]) begin
               chk($sformatf("done_expected_d%0d", d),
                   int'(exp_q[d].size() > 0 && exp_q[d][0] == 2), 1);
               if (exp_q[d].size() > 0 && exp_q[d][0] == 2) void'(exp_q[d].pop_front());
               done_cyc[d] = cyc;
               chk($sformatf("done_outputs_d%0d", d),
                   int'({sout_valid[d], busy[d], din_ready[d], sout[d]}), 0);
            end else begin
               if (exp_q[d].size() > 0 && exp_q[d][0] == 2) begin
                  chk($sformatf("done_missing_d%0d", d), 0, 1);
                  void'(exp_q[d].pop_front());
               end
               if (sout_valid[d]) begin
                  if (exp_q[d].size() == 0 || exp_q[d][0] == 2) begin
                     chk($sformatf("unexpected_bit_d%0d", d), 0, 1);
                  end else begin
                     chk($sformatf("sout_bit_d%0d", d), int'(sout[d]), exp_q[d][0]);
                     if (adv) void'(exp_q[d].pop_front());
                  end
                  chk($sformatf("shift_flags_d%0d", d), int'({busy[d], din_ready[d]}), 2);
               end else begin
                  chk($sformatf("idle_outputs_d%0d", d),
                      int'({sout[d], busy[d], din_ready[d]}), 1);
               end
            end
         end
      end
   end

   initial begin
      int h0, h1;
      logic [7:0] w;
      int d;

      // Reset with a word offered: nothing may load.
      din[0] = 8'hA5; din_valid[0] = 1'b1;
      din[1] = 8'hA5; din_valid[1] = 1'b1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++)
         chk($sformatf("reset_outputs_d%0d", i),
             int'({din_ready[i], busy[i], sout_valid[i], done[i], sout[i]}), 16);
      din_valid[0] = 1'b0;
      din_valid[1] = 1'b0;
      rst = 1'b1;
      mon_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Basic LSB-first frame, then 8'hFF held valid throughout.
      en = 1'b1;
      send(0, 8'hA5, h0);
      din[0] = 8'hFF;
      din_valid[0] = 1'b1;
      send(0, 8'hFF, h1);
      chk("ff_accept_gap", h1 - h0, 10);
      chk("basic_done_latency", done_cyc[0] - h0, 9);
      drain(0, 0);

      // Enable on every 3rd cycle: each bit held three cycles.
      en = 1'b0;
      send(0, 8'h3C, h0);
      for (int i = 0; i < 27; i++) begin
         en = (i % 3 == 2);
         @(posedge clk);
         #1;
      end
      chk("gated_done_latency", done_cyc[0] - h0, 25);
      drain(0, 0);

      // MSB-first, ungated instance, en held low.
      en = 1'b0;
      send(1, 8'h81, h0);
      drain(1, 1);
      chk("msb_done_latency", done_cyc[1] - h0, 9);

      // Mid-frame reset after three bits.
      en = 1'b1;
      send(0, 8'hF0, h0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      exp_q[0].delete();
      exp_q[1].delete();
      rst = 1'b1;
      chk("abort_outputs", int'({sout_valid[0], busy[0], done[0], din_ready[0]}), 1);
      send(0, 8'h0F, h0);
      drain(0, 0);

      // Randomized words and enable patterns.
      for (int i = 0; i < 10; i++) begin
         d = int'($urandom_range(0, 1));
         w = 8'($urandom);
         en = 1'($urandom_range(0, 1));
         send(d, w, h0);
         drain(d, 2);
      end

      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
      $finish;
   end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in/serial-out transmitter with a valid/ready load handshake.
- Serializes a WIDTH-bit word onto a single bit line, one bit per advance strobe.
- The strobe works like a flip-flop enable, and its use is compile-time selectable.
- Used as the sending end of serial links whose receiving end is a chain of enable-gated D flip-flops sampling `sout` when `sout_valid && en`.

Parameters:
- WIDTH, 8: word width in bits; legal range 2..32.
- USE_EN, 1: 1 = shifting advances only on cycles with `en` high; 0 = `en` is ignored and shifting advances every cycle.
- LSB_FIRST, 1: 1 = bit 0 is transmitted first; 0 = bit WIDTH-1 is transmitted first.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: reset, synchronous, active-low; sampled only on the rising edge of clk.
- en, input, 1: bit-advance strobe; ignored when USE_EN=0.
- din, input, WIDTH: parallel word to transmit.
- din_valid, input, 1: producer has a word on `din`.
- din_ready, output, 1: block can accept a word.
- sout, output, 1: serial data bit.
- sout_valid, output, 1: `sout` carries a frame bit.
- busy, output, 1: a frame is in progress.
- done, output, 1: single-cycle pulse after the last bit.

Behaviour:
- Reset (rst=0 at a rising edge):
  - state <= IDLE, shift register <= 0, bit counter <= 0.
  - Outputs next cycle: din_ready=1, sout=0, sout_valid=0, busy=0, done=0.
  - Reset mid-frame aborts the frame; remaining bits are discarded with no done pulse.
  - Reset wins over every other input.
- advance = (USE_EN ? en : 1).
- FSM states: IDLE, SHIFT, DONE. Outputs are decoded from registered state, so no input-to-output combinational path exists except through registers.
- IDLE:
  - Outputs: din_ready=1, busy=0, sout_valid=0, sout=0.
  - Load handshake occurs when din_valid && din_ready at a rising edge: shift register <= din, counter <= 0, state <= SHIFT.
  - `en` is ignored in IDLE.
- SHIFT:
  - Outputs: din_ready=0, busy=1, sout_valid=1.
  - sout = shift register bit 0 if LSB_FIRST, else bit WIDTH-1.
  - On an advance cycle with counter == WIDTH-1: state <= DONE.
  - On an advance cycle otherwise: shift register shifts one position toward the output end, zero-filled, and counter increments.
  - On a cycle with advance=0: everything holds, and sout/sout_valid stay stable.
- DONE:
  - Outputs: done=1, busy=0, sout_valid=0, sout=0, din_ready=0.
  - Unconditionally goes to IDLE next cycle.
- Words offered while din_ready=0 are not captured. The producer must hold din_valid and din until the handshake; changing `din` during SHIFT has no effect.
- Latency with USE_EN=0 and handshake at edge 0:
  - Bit k is on `sout` during cycle k+1, for k = 0..WIDTH-1.
  - done is high in cycle WIDTH+1.
  - din_ready is high again in cycle WIDTH+2.
  - The next handshake can complete at edge WIDTH+2, so back-to-back frames have a minimum 2-cycle gap (DONE plus IDLE).
- With USE_EN=1, each bit stays on `sout` from SHIFT entry or the previous advance until the advance edge that consumes it. A bit held for N cycles is legal.
- Counter width is $clog2(WIDTH). The counter never exceeds WIDTH-1.

Test Plan:
- Reset: assert rst=0 with din_valid=1 and din=8'hA5 for 2 cycles, then release. -> din_ready=1, busy=0, sout_valid=0, done=0; no load occurs during reset.
- Basic frame (USE_EN=1, LSB_FIRST=1, en=1 every cycle): load 8'hA5. -> sout sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles with sout_valid=1, then done=1 for exactly 1 cycle, then din_ready=1.
- Enable gating: load 8'h3C, with en high only every 3rd cycle. -> each bit held exactly 3 cycles, sequence 0,0,1,1,1,1,0,0, done after 24 SHIFT cycles; with en=0, sout is unchanged across edges.
- MSB-first with USE_EN=0 (en held 0): load 8'h81. -> sout 1,0,0,0,0,0,0,1 on cycles 1..8, done in cycle 9 despite en=0.
- Busy protection: during the 8'hA5 frame, drive din=8'hFF with din_valid=1 continuously. -> frame bits are unchanged; 8'hFF is accepted only at the edge after DONE and is then transmitted as eight 1s.
- Mid-frame reset: load 8'hF0, assert rst=0 after 3 bits. -> next cycle sout_valid=0, busy=0, no done pulse; a new load of 8'h0F transmits correctly.
